fp64_addsub_norm: RTL

Double-precision add/subtract and post-normalisation stage placed directly downstream of the 64-bit exponent-alignment stage. It accepts two exponent-aligned 53-bit significands (hidden bit included), their common exponent and the operand signs. It computes the signed magnitude sum or difference, renormalises it iteratively one bit per cycle, and packs an IEEE-754 binary64 result with a single-cycle completion strobe.

---
 rtl/fp64_addsub_norm.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fp64_addsub_norm.sv
// Binary64 add/subtract of exponent-aligned significands with iterative
// one-bit-per-cycle renormalisation and truncating pack.
module fp64_addsub_norm (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic [52:0] Am,
  input  logic [52:0] Bm,
  input  logic [10:0] eSm,
  input  logic        sA,
  input  logic        sB,
  input  logic        sub,
  output logic [63:0] result,
  output logic        done,
  output logic        busy,
  output logic        ovf,
  output logic        unf
);

  typedef enum logic [1:0] {IDLE, CALC, NORM, PACK} state_t;

  state_t      state_reg;
  logic [52:0] a_reg;
  logic [52:0] b_reg;
  logic [10:0] e_reg;
  logic        sa_reg;
  logic        sb_reg;
  logic        sub_reg;
  logic [53:0] mag_reg;
  logic [11:0] exp_reg;
  logic        sign_reg;
  logic        zero_reg;

  logic        eff_sub;
  logic        a_ge_b;

  assign eff_sub = sa_reg ^ sb_reg ^ sub_reg;
  assign a_ge_b  = (a_reg >= b_reg);
  assign busy    = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      e_reg     <= '0;
      sa_reg    <= 1'b0;
      sb_reg    <= 1'b0;
      sub_reg   <= 1'b0;
      mag_reg   <= '0;
      exp_reg   <= '0;
      sign_reg  <= 1'b0;
      zero_reg  <= 1'b0;
      result    <= '0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else if (en) begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= Am;
            b_reg     <= Bm;
            e_reg     <= eSm;
            sa_reg    <= sA;
            sb_reg    <= sB;
            sub_reg   <= sub;
            zero_reg  <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            state_reg <= CALC;
          end
        end
        CALC: begin
          // Subtraction always produces a non-negative magnitude; the sign
          // follows whichever operand is larger.
          if (!eff_sub) begin
            mag_reg  <= {1'b0, a_reg} + {1'b0, b_reg};
            sign_reg <= sa_reg;
          end else if (a_ge_b) begin
            mag_reg  <= {1'b0, a_reg} - {1'b0, b_reg};
            sign_reg <= sa_reg;
          end else begin
            mag_reg  <= {1'b0, b_reg} - {1'b0, a_reg};
            sign_reg <= sb_reg ^ sub_reg;
          end
          exp_reg   <= {1'b0, e_reg};
          state_reg <= NORM;
        end
        NORM: begin
          if (mag_reg == '0) begin
            sign_reg  <= 1'b0;
            zero_reg  <= 1'b1;
            state_reg <= PACK;
          end else if (mag_reg[53]) begin
            mag_reg <= mag_reg >> 1;
            exp_reg <= exp_reg + 12'd1;
          end else if (mag_reg[52]) begin
            state_reg <= PACK;
          end else if (exp_reg <= 12'd1) begin
            // No exponent headroom left for another left shift: flush to zero.
            zero_reg  <= 1'b1;
            unf       <= 1'b1;
            state_reg <= PACK;
          end else begin
            mag_reg <= mag_reg << 1;
            exp_reg <= exp_reg - 12'd1;
          end
        end
        PACK: begin
          if (zero_reg) begin
            result <= {sign_reg, 63'b0};
          end else if (exp_reg >= 12'd2047) begin
            result <= {sign_reg, 11'h7FF, 52'b0};
            ovf    <= 1'b1;
          end else begin
            result <= {sign_reg, exp_reg[10:0], mag_reg[51:0]};
          end
          done      <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
